// File: rtl/renode_pkg.sv
// Shared types and the address-error rule for the APB3 memory completer.
package renode_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    // Misaligned addresses and addresses past the last word are rejected.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/renode_word_mem.sv
// Word-addressed register array: one write port, one combinational read port, cleared on reset.
module renode_word_mem #(
    parameter  int Depth     = 256,
    parameter  int DataWidth = 32,
    localparam int IdxW      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [IdxW-1:0]      i_addr,
    input  logic [DataWidth-1:0] i_wdata,
    output logic [DataWidth-1:0] o_rdata
);

    logic [DataWidth-1:0] r_mem [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb3_mem_completer.sv
// APB3 completer fronting a word memory: programmable wait states, error response,
// sticky protocol-violation flag and a wrapping completed-transfer counter.
module apb3_mem_completer
    import renode_pkg::*;
#(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32,
    parameter int Depth        = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    input  logic [3:0]              wait_states,
    output logic                    protocol_error,
    output logic [15:0]             transfer_count
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    state_t                  r_state, w_next;
    logic [AddressWidth-1:0] r_addr;
    logic                    r_write;
    logic [DataWidth-1:0]    r_wdata;
    logic [3:0]              r_wait;
    logic                    r_perr;
    logic [15:0]             r_xfer_cnt;

    logic                    w_capture;
    logic                    w_viol;
    logic                    w_err;
    logic                    w_we;
    logic [IdxW-1:0]         w_idx;
    logic [DataWidth-1:0]    w_rdata;

    assign w_err = addr_err(32'(r_addr), Depth);
    assign w_idx = r_addr[IdxW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_viol    = penable && !pselx;
        w_we      = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (pselx && !penable) begin
                    w_capture = 1'b1;
                    w_next    = S_WAIT;
                end else if (penable) begin
                    w_viol = 1'b1;
                end
            end
            S_WAIT: begin
                // Deselecting mid-transfer aborts it; nothing is written or counted.
                if (!pselx) begin
                    w_viol = 1'b1;
                    w_next = S_IDLE;
                end else if (r_wait == 4'd0 && penable) begin
                    w_next = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                pready  = 1'b1;
                pslverr = w_err;
                w_we    = r_write && !w_err;
                if (!r_write && !w_err) prdata = w_rdata;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_wait     <= '0;
            r_perr     <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_wait  <= wait_states;
            end else if (r_state == S_WAIT && pselx && r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_viol) r_perr <= 1'b1;
            if (r_state == S_COMPLETE) r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign protocol_error = r_perr;
    assign transfer_count = r_xfer_cnt;

    renode_word_mem #(
        .Depth    (Depth),
        .DataWidth(DataWidth)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_addr (w_idx),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

endmodule

// File: tb/tb_apb3_mem_completer.sv
// Directed bench for apb3_mem_completer with a transaction-level reference model.
module tb_apb3_mem_completer;

    localparam int AW    = 20;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] paddr;
    logic          pselx, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic          pready, pslverr, protocol_error;
    logic [DW-1:0] prdata;
    logic [3:0]    wait_states;
    logic [15:0]   transfer_count;

    apb3_mem_completer #(.AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .wait_states(wait_states),
        .protocol_error(protocol_error), .transfer_count(transfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint        done;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [DEPTH];
    logic [15:0] mcnt;
    longint      perr_from;
    longint      cyc = 0;
    int          errors = 0;
    int          checks = 0;
    longint      last_rdy_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_slverr = 1'b0;
    int          rdy_pulses = 0;

    function automatic logic model_err(input logic [AW-1:0] a);
        return (int'(a) % 4 != 0) || (int'(a) / 4 >= DEPTH);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        mcnt      = '0;
        perr_from = NEVER;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic        e_rdy, e_err, wr;
        logic [31:0] e_rd, a_rd;
        forever begin
            @(negedge clk);
            e_rdy = 1'b0; e_err = 1'b0; e_rd = '0; wr = 1'b0;
            if (q.size() > 0 && q[0].done == cyc) begin
                e_rdy = 1'b1;
                e_err = model_err(q[0].addr);
                wr    = q[0].wr;
                if (!wr && !e_err) e_rd = mmem[int'(q[0].addr) / 4];
            end
            a_rd = (e_rdy && wr) ? 32'h0 : prdata;
            chk("cycle outputs",
                {13'h0, pready, pslverr, protocol_error, transfer_count, a_rd},
                {13'h0, e_rdy, e_err, (cyc >= perr_from), mcnt, e_rd});
            if (pready) begin
                last_rdy_cyc = cyc;
                last_rdata   = prdata;
                last_slverr  = pslverr;
                rdy_pulses++;
            end
            if (e_rdy) begin
                if (wr && !e_err) mmem[int'(q[0].addr) / 4] = q[0].data;
                mcnt = mcnt + 16'd1;
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        model_clear();
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Full transfer; returns the SETUP cycle. With disturb, inputs change after SETUP.
    task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] ws, input bit disturb, output longint s);
        exp_t e;
        pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_states = ws;
        s = cyc;
        e.done = cyc + 2 + longint'(ws); e.wr = wr; e.addr = a; e.data = d;
        q.push_back(e);
        step();
        penable = 1'b1;
        if (disturb) begin
            wait_states = 4'd0;
            paddr       = a ^ 20'h4;
            pwdata      = ~d;
        end
        repeat (int'(ws) + 2) step();
        pselx = 1'b0; penable = 1'b0;
    endtask

    initial begin
        longint s, s0;
        int     p0;
        rst = 1'b1;
        wait_states = 4'd0;
        idle_bus();
        model_clear();
        repeat (3) step();
        chk("reset outputs", {pready, pslverr, protocol_error, transfer_count, prdata}, '0);
        rst = 1'b0;

        // Basic write then read, zero wait states
        xfer(1'b1, 20'h10, 32'hDEADBEEF, 4'd0, 1'b0, s);
        xfer(1'b0, 20'h10, 32'h0, 4'd0, 1'b0, s);
        chk("rd latency ws0", last_rdy_cyc - s, 2);
        chk("rd data 0x10", last_rdata, 32'hDEADBEEF);
        chk("rd slverr 0x10", last_slverr, 0);
        chk("count after 2", transfer_count, 16'd2);

        // Three wait states, inputs disturbed after SETUP
        xfer(1'b1, 20'h20, 32'hA5A55A5A, 4'd1, 1'b1, s);
        xfer(1'b0, 20'h20, 32'h0, 4'd3, 1'b1, s);
        chk("rd latency ws3", last_rdy_cyc - s, 5);
        chk("rd data 0x20", last_rdata, 32'hA5A55A5A);

        // Error responses and the last valid word
        xfer(1'b1, 20'h402, 32'h12345678, 4'd0, 1'b0, s);
        chk("slverr unaligned", last_slverr, 1);
        xfer(1'b1, 20'h400, 32'h12345678, 4'd2, 1'b0, s);
        chk("slverr range", last_slverr, 1);
        xfer(1'b0, 20'h000, 32'h0, 4'd0, 1'b0, s);
        chk("rd data 0x000", last_rdata, 32'h0);
        xfer(1'b0, 20'h400, 32'h0, 4'd0, 1'b0, s);
        chk("rd err data", last_rdata, 32'h0);
        xfer(1'b1, 20'h3FC, 32'h0F0F1234, 4'd0, 1'b0, s);
        xfer(1'b0, 20'h3FC, 32'h0, 4'd0, 1'b0, s);
        chk("rd data 0x3FC", last_rdata, 32'h0F0F1234);
        chk("count after 10", transfer_count, 16'd10);

        // PENABLE without a SETUP, then PENABLE without PSEL
        pselx = 1'b1; penable = 1'b1; perr_from = cyc + 1;
        step();
        pselx = 1'b0; penable = 1'b1;
        step();
        idle_bus();
        repeat (3) step();
        chk("perr no setup", protocol_error, 1);
        chk("count after viol", transfer_count, 16'd10);

        do_reset();
        chk("perr cleared", protocol_error, 0);
        chk("count cleared", transfer_count, 16'd0);

        // Deselect during the wait phase
        xfer(1'b1, 20'h10, 32'h11111111, 4'd0, 1'b0, s);
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h10; pwdata = 32'h22222222;
        wait_states = 4'd5;
        step();
        penable = 1'b1;
        step();
        idle_bus(); perr_from = cyc + 1;
        repeat (3) step();
        chk("perr abort", protocol_error, 1);
        chk("count after abort", transfer_count, 16'd1);
        xfer(1'b0, 20'h10, 32'h0, 4'd0, 1'b0, s);
        chk("rd after abort", last_rdata, 32'h11111111);

        // Reset during the wait phase of a write
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h8; pwdata = 32'h55AA55AA;
        wait_states = 4'd3;
        step();
        penable = 1'b1;
        step();
        rst = 1'b1;
        idle_bus();
        model_clear();
        #1;
        chk("outputs in reset", {pready, pslverr, protocol_error, transfer_count, prdata}, '0);
        repeat (2) step();
        rst = 1'b0;
        xfer(1'b0, 20'h8, 32'h0, 4'd0, 1'b0, s);
        chk("rd 0x8 after reset", last_rdata, 32'h0);

        // Counter wrap over back-to-back transfers
        do_reset();
        p0 = rdy_pulses;
        xfer(1'b1, 20'h10, 32'h0BADF00D, 4'd0, 1'b0, s0);
        for (int i = 0; i < 65535; i++) xfer(1'b0, 20'h10, 32'h0, 4'd0, 1'b0, s);
        chk("count wrapped", transfer_count, 16'd0);
        chk("wrap pulses", rdy_pulses - p0, 65536);
        chk("wrap no gaps", last_rdy_cyc - s0, 196607);
        chk("wrap rd data", last_rdata, 32'h0BADF00D);

        repeat (3) step();
        chk("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb3_mem_completer.md
APB3_MEM_COMPLETER -- requirements
Module: apb3_mem_completer

Interface
REQ-001 SHALL have parameter AddressWidth, default 20, meaning PADDR width in bits.
REQ-002 SHALL have parameter DataWidth, default 32, meaning PWDATA/PRDATA width; only 32 is supported.
REQ-003 SHALL have parameter Depth, default 256, meaning number of 32-bit memory words.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single bus clock (PCLK equivalent).
REQ-005 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 SHALL have ports paddr, pselx, penable, pwrite and pwdata as inputs of widths AddressWidth/1/1/1/DataWidth, meaning the APB3 requester outputs.
REQ-007 SHALL have ports pready, prdata and pslverr as outputs of widths 1/DataWidth/1, meaning the APB3 completer response.
REQ-008 SHALL have port wait_states, input, 4 bits, meaning the number of extra ACCESS cycles inserted before PREADY.
REQ-009 SHALL have port protocol_error, output, 1 bit, meaning a sticky APB sequencing violation flag.
REQ-010 SHALL have port transfer_count, output, 16 bits, meaning the number of completed transfers, wrapping at 0xFFFF to 0.

Function
REQ-011 SHALL implement three states: S_IDLE, S_WAIT and S_COMPLETE.
REQ-012 S_IDLE: when pselx=1 and penable=0, SHALL capture paddr, pwrite, pwdata and wait_states, then move to S_WAIT.
REQ-013 S_WAIT: while the captured count is nonzero, SHALL decrement it each cycle; when it is zero and penable=1, SHALL move to S_COMPLETE.
REQ-014 S_COMPLETE: SHALL assert pready=1 for exactly one cycle, then return to S_IDLE.
REQ-015 Minimum latency: pready SHALL assert in the second ACCESS cycle when wait_states=0, and wait_states cycles later otherwise.
REQ-016 pready, pslverr and prdata SHALL be driven combinationally from state; outside S_COMPLETE all three SHALL be 0.
REQ-017 pslverr SHALL be 1 in S_COMPLETE if the captured address has [1:0]!=0 or address>>2 >= Depth.
REQ-018 Write without error: mem[address>>2] SHALL take the captured pwdata on the S_COMPLETE clock edge; an erroring write SHALL leave memory unchanged.
REQ-019 Read: prdata SHALL equal mem[address>>2] in S_COMPLETE; an erroring read SHALL return 0.
REQ-020 transfer_count SHALL increment on every S_COMPLETE cycle, including erroring transfers.
REQ-021 Changes to wait_states, paddr or pwdata after the SETUP cycle SHALL have no effect on the current transfer.
REQ-022 penable=1 while pselx=0, or penable=1 in S_IDLE without a prior setup, SHALL set protocol_error and SHALL NOT start a transfer.
REQ-023 pselx dropping in S_WAIT SHALL abort to S_IDLE, set protocol_error, perform no write and no transfer_count increment.
REQ-024 Back-to-back transfers SHALL be accepted: a new SETUP in the cycle after S_COMPLETE SHALL be handled per REQ-012.
REQ-025 Once set, protocol_error SHALL be cleared only by rst.

Reset
REQ-026 While rst=1, the state SHALL be S_IDLE, and pready, pslverr, prdata, protocol_error and transfer_count SHALL all be 0.
REQ-027 Memory contents SHALL clear to 0 on reset.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no memory write.
REQ-029 After rst deasserts, the first SETUP SHALL be accepted no earlier than the next rising clk edge.

Structure
REQ-030 state_t and the error-condition helper function SHALL live in renode_pkg.
REQ-031 The word array with its write port and reset clear SHALL be one sub-module, renode_word_mem, parameterised by Depth.
REQ-032 The top level SHALL contain only the FSM, the wait counter, the capture registers, transfer_count and error logic.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, wait_states=0, then read 0x10: pready on the 2nd ACCESS cycle, prdata=0xDEADBEEF, pslverr=0, transfer_count=2.
REQ-034 Read 0x20 with wait_states=3: pready asserts exactly 3 cycles later than in REQ-033; changing wait_states to 0 mid-transfer has no effect.
REQ-035 Write 0x12345678 to 0x402 (unaligned), then write to 0x400 (Depth=256, out of range): pslverr=1 on both; a read of 0x000 returns 0 and memory is unchanged.
REQ-036 pselx dropped during S_WAIT with wait_states=5: protocol_error=1, no write, transfer_count unchanged.
REQ-037 Assert rst during S_WAIT of a write to 0x8: outputs are 0 immediately; after release, a read of 0x8 returns 0.
REQ-038 With 65536 back-to-back reads: transfer_count wraps to 0 and no cycle is lost between transfers.
